// File: rtl/master_in_port_pkg.sv
// -----------------------------------------------------------------------------
// master_in_port_pkg
// Shared definitions for the bus read-data serial link between the slave
// output port and the master input port:
//   - BUS_DATA_WIDTH / BUS_CNT_W : default word width and bit-counter width
//   - rx_state_e                 : receiver state encoding (IDLE=0, RX=1, HOLD=2)
//   - done_flag_error()          : framing check of the slave "last bit" flag
// -----------------------------------------------------------------------------
package master_in_port_pkg;

    localparam int BUS_DATA_WIDTH = 8;
    localparam int BUS_CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1,
        HOLD = 2'd2
    } rx_state_e;

    // The slave flags its final bit with done; anywhere else the flag must be
    // low. Outside RX there is no bit on the line, so done high is an error.
    function automatic logic done_flag_error(
        input rx_state_e st,
        input logic      last_bit,
        input logic      done
    );
        logic err;
        case (st)
            RX:      err = (done != last_bit);
            IDLE:    err = done;
            HOLD:    err = done;
            default: err = done;
        endcase
        return err;
    endfunction

endpackage : master_in_port_pkg

// File: rtl/master_in_port.sv
// -----------------------------------------------------------------------------
// master_in_port
// Receive side of the master port. After a slave_valid/master_ready handshake
// it deserializes a DATA_WIDTH-bit word (LSB first, one bit per clock) from
// rx_data and presents it on a registered valid/ready output stage. A word
// that completes while the output register is still occupied is parked in the
// shift register (HOLD) so nothing is lost.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   rx_en                core permits a new transfer to start
//   slave_valid          slave has a word to send
//   master_ready         (state==IDLE) & rx_en, combinational
//   rx_data              serial data, LSB first
//   slave_tx_done        slave "last bit" flag
//   dataout, out_valid   registered received word and its valid flag
//   out_ready            core consumes dataout on out_valid & out_ready
//   rx_error             sticky framing-error flag
//   error_clr            synchronous clear of rx_error
//
// Configuration macro: MASTER_IN_DONE_CHECK_EN
//   defined   : slave_tx_done is checked every cycle, rx_error is live
//   undefined : rx_error tied to 0; slave_tx_done and error_clr ignored
// CNT_W must equal clog2(DATA_WIDTH).
// -----------------------------------------------------------------------------
module master_in_port
    import master_in_port_pkg::*;
#(
    parameter int DATA_WIDTH = BUS_DATA_WIDTH,
    parameter int CNT_W      = BUS_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_en,
    input  logic                  slave_valid,
    output logic                  master_ready,
    input  logic                  rx_data,
    input  logic                  slave_tx_done,
    output logic [DATA_WIDTH-1:0] dataout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  rx_error,
    input  logic                  error_clr
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    rx_state_e             state_q,     state_d;
    logic [CNT_W-1:0]      bit_cnt_q,   bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q,     shreg_d;
    logic [DATA_WIDTH-1:0] dataout_q,   dataout_d;
    logic                  out_valid_q, out_valid_d;

    logic [DATA_WIDTH-1:0] shift_w_s;
    logic                  last_bit_s;
    logic                  master_ready_s;

    assign master_ready_s = (state_q == IDLE) & rx_en;
    assign shift_w_s      = {rx_data, shreg_q[DATA_WIDTH-1:1]};
    assign last_bit_s     = (bit_cnt_q == LAST_CNT);

    assign master_ready = master_ready_s;
    assign dataout      = dataout_q;
    assign out_valid    = out_valid_q;

    // Next-state logic for the receive FSM, shift register and output stage.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        dataout_d   = dataout_q;
        out_valid_d = out_valid_q;

        // Consumption drains the output stage unless a load below refills it.
        if (out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            IDLE: begin
                if (slave_valid & master_ready_s) begin
                    state_d   = RX;
                    bit_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d   = IDLE;
                end
            end

            RX: begin
                shreg_d = shift_w_s;
                if (last_bit_s) begin
                    bit_cnt_d = {CNT_W{1'b0}};
                    // Load directly when the output slot is free or being
                    // emptied this edge; otherwise park the word in shreg.
                    if (!out_valid_q | out_ready) begin
                        dataout_d   = shift_w_s;
                        out_valid_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d     = HOLD;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
            end

            HOLD: begin
                // out_valid is necessarily set here, so out_ready is a consume.
                if (out_ready) begin
                    dataout_d   = shreg_q;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d     = HOLD;
                end
            end

            default: begin
                state_d   = IDLE;
                bit_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= {CNT_W{1'b0}};
            shreg_q     <= {DATA_WIDTH{1'b0}};
            dataout_q   <= {DATA_WIDTH{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            dataout_q   <= dataout_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef MASTER_IN_DONE_CHECK_EN
    logic rx_error_q, rx_error_d;
    logic err_set_s;

    // Sticky error flag; a new error wins over a same-cycle clear.
    always_comb begin
        err_set_s = done_flag_error(state_q, last_bit_s, slave_tx_done);
        if (err_set_s) begin
            rx_error_d = 1'b1;
        end else if (error_clr) begin
            rx_error_d = 1'b0;
        end else begin
            rx_error_d = rx_error_q;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_error_q <= 1'b0;
        end else begin
            rx_error_q <= rx_error_d;
        end
    end

    assign rx_error = rx_error_q;
`else
    // Framing check compiled out: the inputs stay on the port list but are
    // deliberately left without function.
    logic unused_done_s;
    assign unused_done_s = slave_tx_done ^ error_clr;
    assign rx_error      = 1'b0;
`endif

endmodule : master_in_port

// File: tb/tb_master_in_port.sv
// -----------------------------------------------------------------------------
// tb_master_in_port
// Directed bench for master_in_port. A slave-port model task drives the
// handshake and serial bits and pushes the expected word into a scoreboard
// queue; an independent monitor pops and compares whenever the DUT hands a
// word to the core (out_valid & out_ready).
// -----------------------------------------------------------------------------
module tb_master_in_port;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rx_en;
    logic          slave_valid;
    logic          master_ready;
    logic          rx_data;
    logic          slave_tx_done;
    logic [DW-1:0] dataout;
    logic          out_valid;
    logic          out_ready;
    logic          rx_error;
    logic          error_clr;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    // Free-running cycle counter for spacing measurements.
    always @(posedge clk) cyc <= cyc + 1;

    master_in_port #(.DATA_WIDTH(8), .CNT_W(3)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_en        (rx_en),
        .slave_valid  (slave_valid),
        .master_ready (master_ready),
        .rx_data      (rx_data),
        .slave_tx_done(slave_tx_done),
        .dataout      (dataout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .rx_error     (rx_error),
        .error_clr    (error_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: sample 1 time unit after the falling edge, away from the
    // rising edge; a word is consumed at the next rising edge.
    always @(negedge clk) begin
        logic [7:0] exp_w;
        #1;
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h, expected no word", dataout);
            end else begin
                exp_w = exp_q.pop_front();
                check("scoreboard_word", 32'(dataout), 32'(exp_w));
            end
        end
    end

    // Slave output port model. Called at a falling edge; returns at the
    // falling edge after the last driven bit. Only full words are expected.
    task automatic send_word(input logic [7:0] w, input int done_pos, input int nbits,
                             input int drop_en_at, input bit chk_lat);
        int n;
        n = 0;
        if (nbits == 8) exp_q.push_back(w);
        slave_valid = 1'b1;
        while (master_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("handshake_ready", 32'(master_ready), 32'(1));
        if (master_ready !== 1'b1) begin
            slave_valid = 1'b0;
            return;
        end
        @(negedge clk);                    // handshake edge E0 has passed
        slave_valid = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            rx_data       = w[i];
            slave_tx_done = (i == done_pos);
            if (i == drop_en_at) rx_en = 1'b0;
            if (chk_lat && i == 7) check("valid_before_E8", 32'(out_valid), 32'(0));
            @(negedge clk);                // edge E(i+1) has passed
        end
        rx_data       = 1'b0;
        slave_tx_done = 1'b0;
    endtask

    initial begin
        int last_cyc;
        int wait_n;

        reset_n       = 1'b0;
        rx_en         = 1'b0;
        slave_valid   = 1'b0;
        rx_data       = 1'b0;
        slave_tx_done = 1'b0;
        out_ready     = 1'b1;
        error_clr     = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ready_en0", 32'(master_ready), 32'(0));
        rx_en = 1'b1;
        #1;
        check("rst_ready_en1", 32'(master_ready), 32'(1));
        check("rst_valid",     32'(out_valid),    32'(0));
        check("rst_dataout",   32'(dataout),      32'(0));
        check("rst_error",     32'(rx_error),     32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Single word 0xA5, valid exactly after E8
        send_word(8'hA5, 7, 8, -1, 1'b1);
        check("single_valid", 32'(out_valid), 32'(1));
        check("single_data",  32'(dataout),   32'(8'hA5));
        check("single_error", 32'(rx_error),  32'(0));
        @(negedge clk);

        // Backpressure: 0x3C held, 0xC3 parked in HOLD, third word waits
        out_ready = 1'b0;
        send_word(8'h3C, 7, 8, -1, 1'b0);
        check("bp_first_valid", 32'(out_valid), 32'(1));
        check("bp_first_data",  32'(dataout),   32'(8'h3C));
        send_word(8'hC3, 7, 8, -1, 1'b0);
        check("hold_ready", 32'(master_ready), 32'(0));
        check("hold_data",  32'(dataout),      32'(8'h3C));
        fork
            send_word(8'h11, 7, 8, -1, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("hold_refuse", 32'(master_ready), 32'(0));
                    check("hold_stable", 32'(dataout),      32'(8'h3C));
                end
                out_ready = 1'b1;
                @(negedge clk);
                check("unbroken_valid", 32'(out_valid), 32'(1));
                check("second_word",    32'(dataout),   32'(8'hC3));
            end
        join
        @(negedge clk);

        // Reset after 4 bits of 0x5A, then a clean 0xFF
        send_word(8'h5A, 7, 4, -1, 1'b0);
        reset_n = 1'b0;
        #1;
        check("midrst_valid",   32'(out_valid),    32'(0));
        check("midrst_dataout", 32'(dataout),      32'(0));
        check("midrst_error",   32'(rx_error),     32'(0));
        check("midrst_ready",   32'(master_ready), 32'(1));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_word(8'hFF, 7, 8, -1, 1'b0);
        check("after_rst_data", 32'(dataout), 32'(8'hFF));
        @(negedge clk);

        // Gating: slave_valid ignored while rx_en is low
        rx_en       = 1'b0;
        slave_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("gated_ready", 32'(master_ready), 32'(0));
        end
        check("gated_no_word", 32'(out_valid), 32'(0));
        slave_valid = 1'b0;
        rx_en       = 1'b1;
        @(negedge clk);
        // rx_en dropped before E3: word still completes
        send_word(8'h81, 7, 8, 2, 1'b0);
        check("drop_en_data",  32'(dataout),      32'(8'h81));
        check("drop_en_ready", 32'(master_ready), 32'(0));
        rx_en = 1'b1;
        @(negedge clk);

        // Done-flag framing check
        send_word(8'h5A, 6, 8, -1, 1'b0);
`ifdef MASTER_IN_DONE_CHECK_EN
        check("done_early_error", 32'(rx_error), 32'(1));
        error_clr = 1'b1;
        @(negedge clk);
        error_clr = 1'b0;
        check("error_cleared", 32'(rx_error), 32'(0));
        send_word(8'h00, 7, 8, -1, 1'b0);
        check("good_frame_error", 32'(rx_error), 32'(0));
`else
        check("error_tied_low", 32'(rx_error), 32'(0));
`endif
        @(negedge clk);

        // Back-to-back random words, 9-cycle spacing
        last_cyc = 0;
        for (int i = 0; i < 16; i++) begin
            send_word(8'($urandom), 7, 8, -1, 1'b0);
            if (i > 0) check("b2b_spacing", 32'(cyc - last_cyc), 32'(9));
            last_cyc = cyc;
        end

        // Drain scoreboard
        wait_n = 0;
        while (exp_q.size() != 0 && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_master_in_port
